// File: rtl/ddr_axi_responder.sv
// rtl/ddr_axi_responder.sv - single-outstanding AXI-style responder in front of a 128-bit word RAM
module ddr_axi_responder #(
  parameter int MEM_WORDS = 1024,
  parameter int ID_WIDTH  = 8
) (
  input  logic                io_memoryClk,
  input  logic                io_memoryReset,
  input  logic                io_ddrA_arw_valid,
  output logic                io_ddrA_arw_ready,
  input  logic [31:0]         io_ddrA_arw_payload_addr,
  input  logic [ID_WIDTH-1:0] io_ddrA_arw_payload_id,
  input  logic [7:0]          io_ddrA_arw_payload_len,
  input  logic [2:0]          io_ddrA_arw_payload_size,
  input  logic [1:0]          io_ddrA_arw_payload_burst,
  input  logic                io_ddrA_arw_payload_write,
  input  logic                io_ddrA_w_valid,
  output logic                io_ddrA_w_ready,
  input  logic [127:0]        io_ddrA_w_payload_data,
  input  logic [15:0]         io_ddrA_w_payload_strb,
  input  logic                io_ddrA_w_payload_last,
  output logic                io_ddrA_b_valid,
  input  logic                io_ddrA_b_ready,
  output logic [ID_WIDTH-1:0] io_ddrA_b_payload_id,
  output logic [1:0]          io_ddrA_b_payload_resp,
  output logic                io_ddrA_r_valid,
  input  logic                io_ddrA_r_ready,
  output logic [127:0]        io_ddrA_r_payload_data,
  output logic [ID_WIDTH-1:0] io_ddrA_r_payload_id,
  output logic [1:0]          io_ddrA_r_payload_resp,
  output logic                io_ddrA_r_payload_last
);

  localparam int IDX_W = $clog2(MEM_WORDS);
  localparam logic [32:0] ADDR_LIMIT = 33'(MEM_WORDS) << 4;

  typedef enum logic [1:0] {IDLE, WRITE, WRESP, READ} stateType;

  stateType            state;
  logic [127:0]        mem [MEM_WORDS];
  logic [IDX_W-1:0]    wordIdx;
  logic [ID_WIDTH-1:0] idReg;
  logic [7:0]          lenReg;
  logic [1:0]          burstReg;
  logic                decErr;
  logic [8:0]          beatCnt;
  logic                arwReady, wReady, bValid, rValid, rLast;
  logic [ID_WIDTH-1:0] bId, rId;
  logic [1:0]          bResp, rResp;
  logic [127:0]        rdData;

  // Size and the write last flag carry no information here: every beat is a full word
  // and the beat counter alone ends a burst.
  logic unusedBits;
  assign unusedBits = ^{io_ddrA_arw_payload_size, io_ddrA_w_payload_last};

  logic             arwFire, wFire, memWe, rLoad, lastBeat;
  logic [IDX_W-1:0] nextIdx;

  assign arwFire  = io_ddrA_arw_valid && arwReady;
  assign wFire    = (state == WRITE) && io_ddrA_w_valid && wReady;
  assign memWe    = wFire && !decErr && !io_memoryReset;
  assign lastBeat = (beatCnt == {1'b0, lenReg});
  // A new read beat is fetched whenever the output register is empty or is being drained
  // by a non-final handshake, which keeps stalled payloads untouched.
  assign rLoad    = (state == READ) && (!rValid || (io_ddrA_r_ready && !rLast));
  assign nextIdx  = (burstReg == 2'b00) ? wordIdx : wordIdx + IDX_W'(1);

  always_ff @(posedge io_memoryClk) begin
    if (memWe) begin
      for (int i = 0; i < 16; i++) begin
        if (io_ddrA_w_payload_strb[i]) begin
          mem[wordIdx][i*8 +: 8] <= io_ddrA_w_payload_data[i*8 +: 8];
        end
      end
    end
    if (rLoad) begin
      rdData <= decErr ? '0 : mem[wordIdx];
    end
  end

  always_ff @(posedge io_memoryClk) begin
    if (io_memoryReset) begin
      state    <= IDLE;
      arwReady <= 1'b0;
      wReady   <= 1'b0;
      bValid   <= 1'b0;
      rValid   <= 1'b0;
      rLast    <= 1'b0;
      bId      <= '0;
      bResp    <= 2'b00;
      rId      <= '0;
      rResp    <= 2'b00;
      beatCnt  <= '0;
      wordIdx  <= '0;
      idReg    <= '0;
      lenReg   <= '0;
      burstReg <= 2'b00;
      decErr   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (arwFire) begin
            wordIdx  <= io_ddrA_arw_payload_addr[IDX_W+3:4];
            idReg    <= io_ddrA_arw_payload_id;
            lenReg   <= io_ddrA_arw_payload_len;
            burstReg <= io_ddrA_arw_payload_burst;
            decErr   <= ({1'b0, io_ddrA_arw_payload_addr} >= ADDR_LIMIT);
            beatCnt  <= '0;
            arwReady <= 1'b0;
            if (io_ddrA_arw_payload_write) begin
              state  <= WRITE;
              wReady <= 1'b1;
            end else begin
              state  <= READ;
            end
          end else begin
            arwReady <= 1'b1;
          end
        end
        WRITE: begin
          if (wFire) begin
            beatCnt <= beatCnt + 9'd1;
            wordIdx <= nextIdx;
            if (lastBeat) begin
              wReady <= 1'b0;
              bValid <= 1'b1;
              bId    <= idReg;
              bResp  <= decErr ? 2'b11 : 2'b00;
              state  <= WRESP;
            end
          end
        end
        WRESP: begin
          if (io_ddrA_b_ready) begin
            bValid   <= 1'b0;
            arwReady <= 1'b1;
            state    <= IDLE;
          end
        end
        READ: begin
          if (rValid && io_ddrA_r_ready && rLast) begin
            rValid   <= 1'b0;
            rLast    <= 1'b0;
            arwReady <= 1'b1;
            state    <= IDLE;
          end else if (rLoad) begin
            rValid  <= 1'b1;
            rLast   <= lastBeat;
            rId     <= idReg;
            rResp   <= decErr ? 2'b11 : 2'b00;
            beatCnt <= beatCnt + 9'd1;
            wordIdx <= nextIdx;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign io_ddrA_arw_ready      = arwReady;
  assign io_ddrA_w_ready        = wReady;
  assign io_ddrA_b_valid        = bValid;
  assign io_ddrA_b_payload_id   = bId;
  assign io_ddrA_b_payload_resp = bResp;
  assign io_ddrA_r_valid        = rValid;
  assign io_ddrA_r_payload_data = rdData;
  assign io_ddrA_r_payload_id   = rId;
  assign io_ddrA_r_payload_resp = rResp;
  assign io_ddrA_r_payload_last = rLast;

endmodule

// File: tb/tb_ddr_axi_responder.sv
// tb/tb_ddr_axi_responder.sv - scoreboard bench for ddr_axi_responder
module tb_ddr_axi_responder;
  localparam int MEM_WORDS = 1024;
  localparam int ID_WIDTH  = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic                arwValid, arwReady, arwWrite;
  logic [31:0]         arwAddr;
  logic [ID_WIDTH-1:0] arwId;
  logic [7:0]          arwLen;
  logic [2:0]          arwSize;
  logic [1:0]          arwBurst;
  logic                wValid, wReady, wLast;
  logic [127:0]        wData;
  logic [15:0]         wStrb;
  logic                bValid, bReady;
  logic [ID_WIDTH-1:0] bId;
  logic [1:0]          bResp;
  logic                rValid, rReady, rLast;
  logic [127:0]        rData;
  logic [ID_WIDTH-1:0] rId;
  logic [1:0]          rResp;

  ddr_axi_responder #(.MEM_WORDS(MEM_WORDS), .ID_WIDTH(ID_WIDTH)) dut (
    .io_memoryClk(clk), .io_memoryReset(rst),
    .io_ddrA_arw_valid(arwValid), .io_ddrA_arw_ready(arwReady),
    .io_ddrA_arw_payload_addr(arwAddr), .io_ddrA_arw_payload_id(arwId),
    .io_ddrA_arw_payload_len(arwLen), .io_ddrA_arw_payload_size(arwSize),
    .io_ddrA_arw_payload_burst(arwBurst), .io_ddrA_arw_payload_write(arwWrite),
    .io_ddrA_w_valid(wValid), .io_ddrA_w_ready(wReady),
    .io_ddrA_w_payload_data(wData), .io_ddrA_w_payload_strb(wStrb),
    .io_ddrA_w_payload_last(wLast),
    .io_ddrA_b_valid(bValid), .io_ddrA_b_ready(bReady),
    .io_ddrA_b_payload_id(bId), .io_ddrA_b_payload_resp(bResp),
    .io_ddrA_r_valid(rValid), .io_ddrA_r_ready(rReady),
    .io_ddrA_r_payload_data(rData), .io_ddrA_r_payload_id(rId),
    .io_ddrA_r_payload_resp(rResp), .io_ddrA_r_payload_last(rLast)
  );

  typedef struct packed {
    logic [127:0]        data;
    logic [ID_WIDTH-1:0] id;
    logic [1:0]          resp;
    logic                last;
  } rBeatT;
  typedef struct packed {
    logic [ID_WIDTH-1:0] id;
    logic [1:0]          resp;
  } bRespT;

  rBeatT        rExpQ[$];
  bRespT        bExpQ[$];
  int           compared = 0;
  int           mismatched = 0;
  int           rSeen = 0;
  int           rMode = 1;
  logic [127:0] wBuf [8];
  logic [15:0]  strbV;

  task automatic checkVec(input string name, input logic [138:0] act, input logic [138:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic checkBit(input string name, input logic act, input logic exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s actual=%b required=%b", name, act, exp);
    end
  endtask

  task automatic checkInt(input string name, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  function automatic logic [127:0] pat(input int k);
    return {32'(k), 32'hA5A5_0000 + 32'(k), ~32'(k), 32'h1234_0000 ^ 32'(k)};
  endfunction

  function automatic rBeatT mkBeat(input logic [127:0] d, input logic [7:0] id,
                                   input logic [1:0] resp, input logic last);
    rBeatT b;
    b.data = d; b.id = id; b.resp = resp; b.last = last;
    return b;
  endfunction

  // Monitor: compares every r/b handshake against the scoreboard and checks stall stability.
  initial begin
    rBeatT cur, held;
    bit    stallPending;
    stallPending = 0;
    held = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        stallPending = 0;
      end else begin
        cur = {rData, rId, rResp, rLast};
        if (stallPending) begin
          checkBit("stall_r_valid", rValid, 1'b1);
          checkVec("stall_payload", 139'(cur), 139'(held));
        end
        if (rValid && rReady) begin
          rSeen++;
          if (rExpQ.size() == 0) begin
            compared++; mismatched++;
            $display("FAIL r_unexpected actual=%h required=no beat", cur);
          end else begin
            checkVec("r_beat", 139'(cur), 139'(rExpQ.pop_front()));
          end
        end
        stallPending = rValid && !rReady;
        held = cur;
        if (bValid && bReady) begin
          if (bExpQ.size() == 0) begin
            compared++; mismatched++;
            $display("FAIL b_unexpected actual=%h required=no response", {bId, bResp});
          end else begin
            checkVec("b_resp", 139'({bId, bResp}), 139'(bExpQ.pop_front()));
          end
        end
      end
    end
  end

  initial begin
    rReady = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      rReady = (rMode == 2) ? 1'($urandom_range(0, 1)) : (rMode == 1);
    end
  end

  initial begin
    #400000;
    $display("FAIL global_timeout actual=running required=finished");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched + 1);
    $fatal(1);
  end

  task automatic sendArw(input logic [31:0] addr, input logic [7:0] id, input logic [7:0] len,
                         input logic [1:0] burst, input logic write);
    int t;
    arwAddr = addr; arwId = id; arwLen = len; arwBurst = burst; arwWrite = write;
    arwSize = 3'd4; arwValid = 1'b1;
    t = 0;
    @(negedge clk);
    while (!arwReady && t < 100) begin
      @(negedge clk);
      t++;
    end
    checkBit("arw_accept", arwReady, 1'b1);
    @(posedge clk); #1;
    arwValid = 1'b0;
  endtask

  task automatic doWrite(input logic [31:0] addr, input logic [7:0] id, input logic [7:0] len,
                         input logic [1:0] burst, input logic [1:0] expResp,
                         input int nSend, input bit expectB);
    int t;
    if (expectB) bExpQ.push_back({id, expResp});
    sendArw(addr, id, len, burst, 1'b1);
    for (int k = 0; k < nSend; k++) begin
      wData = wBuf[k]; wStrb = strbV; wLast = (k == int'(len)); wValid = 1'b1;
      t = 0;
      @(negedge clk);
      while (!wReady && t < 100) begin
        @(negedge clk);
        t++;
      end
      checkBit("w_accept", wReady, 1'b1);
      @(posedge clk); #1;
    end
    wValid = 1'b0;
    if (expectB) checkBit("b_latency", bValid, 1'b1);
  endtask

  task automatic waitDrain();
    int t;
    t = 0;
    while ((rExpQ.size() != 0 || bExpQ.size() != 0) && t < 2000) begin
      @(posedge clk); #1;
      t++;
    end
    checkInt("drain_r", rExpQ.size(), 0);
    checkInt("drain_b", bExpQ.size(), 0);
    rExpQ.delete();
    bExpQ.delete();
    @(posedge clk); #1;
  endtask

  initial begin
    int base;
    arwValid = 0; arwAddr = 0; arwId = 0; arwLen = 0; arwSize = 0; arwBurst = 0; arwWrite = 0;
    wValid = 0; wData = 0; wStrb = 0; wLast = 0; bReady = 1'b1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkBit("rst_arw_ready", arwReady, 1'b0);
    checkBit("rst_w_ready", wReady, 1'b0);
    checkBit("rst_b_valid", bValid, 1'b0);
    checkBit("rst_r_valid", rValid, 1'b0);
    checkBit("rst_r_last", rLast, 1'b0);
    checkVec("rst_b_id_resp", 139'({bId, bResp}), 139'(0));
    checkVec("rst_r_id_resp", 139'({rId, rResp}), 139'(0));
    rst = 1'b0;
    @(posedge clk); #1;
    checkBit("arw_ready_after_reset", arwReady, 1'b1);

    // Single-beat write then read back
    wBuf[0] = 128'h0011_2233_4455_6677_8899_AABB_CCDD_EEFF; strbV = 16'hFFFF;
    doWrite(32'h100, 8'h5A, 8'd0, 2'b01, 2'b00, 1, 1);
    waitDrain();
    rExpQ.push_back(mkBeat(128'h0011_2233_4455_6677_8899_AABB_CCDD_EEFF, 8'h5B, 2'b00, 1'b1));
    sendArw(32'h100, 8'h5B, 8'd0, 2'b01, 1'b0);
    waitDrain();

    // INCR burst of 4 with latency and back-to-back checks
    for (int k = 0; k < 4; k++) wBuf[k] = pat(k);
    doWrite(32'h200, 8'h11, 8'd3, 2'b01, 2'b00, 4, 1);
    waitDrain();
    for (int k = 0; k < 4; k++) rExpQ.push_back(mkBeat(pat(k), 8'h12, 2'b00, k == 3));
    sendArw(32'h200, 8'h12, 8'd3, 2'b01, 1'b0);
    checkBit("r_lat_cycle1", rValid, 1'b0);
    @(posedge clk); #1;
    checkBit("r_lat_cycle2", rValid, 1'b1);
    for (int k = 1; k < 4; k++) begin
      @(posedge clk); #1;
      checkBit("r_back_to_back", rValid, 1'b1);
    end
    @(posedge clk); #1;
    checkBit("r_valid_drop", rValid, 1'b0);
    waitDrain();

    // Partial strobe over an all-ones word
    wBuf[0] = {128{1'b1}}; strbV = 16'hFFFF;
    doWrite(32'h400, 8'h21, 8'd0, 2'b01, 2'b00, 1, 1);
    wBuf[0] = '0; strbV = 16'h000F;
    doWrite(32'h400, 8'h22, 8'd0, 2'b01, 2'b00, 1, 1);
    waitDrain();
    rExpQ.push_back(mkBeat(128'hFFFFFFFF_FFFFFFFF_FFFFFFFF_00000000, 8'h23, 2'b00, 1'b1));
    sendArw(32'h400, 8'h23, 8'd0, 2'b01, 1'b0);
    waitDrain();

    // Eight-beat read under random backpressure
    for (int k = 0; k < 8; k++) wBuf[k] = pat(16 + k);
    strbV = 16'hFFFF;
    doWrite(32'h500, 8'h31, 8'd7, 2'b01, 2'b00, 8, 1);
    waitDrain();
    for (int k = 0; k < 8; k++) rExpQ.push_back(mkBeat(pat(16 + k), 8'h32, 2'b00, k == 7));
    rMode = 2;
    sendArw(32'h500, 8'h32, 8'd7, 2'b01, 1'b0);
    waitDrain();
    rMode = 1;

    // Decode errors on read and write
    rExpQ.push_back(mkBeat('0, 8'h33, 2'b11, 1'b0));
    rExpQ.push_back(mkBeat('0, 8'h33, 2'b11, 1'b1));
    sendArw(32'h4000, 8'h33, 8'd1, 2'b01, 1'b0);
    waitDrain();
    wBuf[0] = pat(99);
    doWrite(32'h4000, 8'h34, 8'd0, 2'b01, 2'b11, 1, 1);
    waitDrain();

    // FIXED burst keeps only the final beat
    for (int k = 0; k < 3; k++) wBuf[k] = pat(30 + k);
    doWrite(32'h300, 8'h35, 8'd2, 2'b00, 2'b00, 3, 1);
    waitDrain();
    rExpQ.push_back(mkBeat(pat(32), 8'h36, 2'b00, 1'b0));
    rExpQ.push_back(mkBeat(pat(32), 8'h36, 2'b00, 1'b1));
    sendArw(32'h300, 8'h36, 8'd1, 2'b00, 1'b0);
    waitDrain();

    // INCR wraps from the top word to word 0
    wBuf[0] = pat(40); wBuf[1] = pat(41);
    doWrite(32'h3FF0, 8'h37, 8'd1, 2'b01, 2'b00, 2, 1);
    waitDrain();
    rExpQ.push_back(mkBeat(pat(41), 8'h38, 2'b00, 1'b1));
    sendArw(32'h0, 8'h38, 8'd0, 2'b01, 1'b0);
    waitDrain();

    // Reset during a read: abort, then the same data reads back
    for (int k = 0; k < 8; k++) rExpQ.push_back(mkBeat(pat(16 + k), 8'h41, 2'b00, k == 7));
    base = rSeen;
    sendArw(32'h500, 8'h41, 8'd7, 2'b01, 1'b0);
    for (int t = 0; t < 50 && rSeen < base + 2; t++) begin
      @(posedge clk); #1;
    end
    checkInt("beats_before_reset", rSeen - base, 2);
    rst = 1'b1; rMode = 0;
    @(posedge clk); #1;
    checkBit("reset_r_valid", rValid, 1'b0);
    checkBit("reset_arw_ready", arwReady, 1'b0);
    rExpQ.delete();
    rst = 1'b0; rMode = 1;
    @(posedge clk); #1;
    checkBit("arw_ready_after_reset2", arwReady, 1'b1);
    for (int k = 0; k < 8; k++) rExpQ.push_back(mkBeat(pat(16 + k), 8'h42, 2'b00, k == 7));
    sendArw(32'h500, 8'h42, 8'd7, 2'b01, 1'b0);
    waitDrain();

    // Reset during a write: completed beats persist, no response
    for (int k = 0; k < 4; k++) wBuf[k] = pat(50 + k);
    doWrite(32'h600, 8'h51, 8'd3, 2'b01, 2'b00, 2, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    checkBit("abort_b_valid", bValid, 1'b0);
    rst = 1'b0;
    @(posedge clk); #1;
    rExpQ.push_back(mkBeat(pat(50), 8'h52, 2'b00, 1'b0));
    rExpQ.push_back(mkBeat(pat(51), 8'h52, 2'b00, 1'b1));
    sendArw(32'h600, 8'h52, 8'd1, 2'b01, 1'b0);
    waitDrain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/ddr_axi_responder.md
DDR_AXI_RESPONDER -- requirements
Module: ddr_axi_responder

Interface
REQ-001 The block SHALL have parameter MEM_WORDS, default 1024, meaning number of 128-bit words of backing RAM (power of two).
REQ-002 The block SHALL have parameter ID_WIDTH, default 8, meaning width of all transaction ID fields.
REQ-003 The block SHALL have one clock; reset is synchronous and active-high.
REQ-004 io_memoryClk  input  1  sole clock, all logic rising-edge.
REQ-005 io_memoryReset  input  1  synchronous active-high reset.
REQ-006 io_ddrA_arw_valid/ready  input/output  1/1  combined address channel handshake.
REQ-007 io_ddrA_arw_payload_addr  input  32  byte address.
REQ-008 io_ddrA_arw_payload_id/len/size/burst/write  input  ID_WIDTH/8/3/2/1  ID, beats-1, size, burst type, 1=write.
REQ-009 io_ddrA_w_valid/ready  input/output  1/1  write data handshake.
REQ-010 io_ddrA_w_payload_data/strb/last  input  128/16/1  write data, byte enables, last flag.
REQ-011 io_ddrA_b_valid/ready  output/input  1/1  write response handshake.
REQ-012 io_ddrA_b_payload_id/resp  output  ID_WIDTH/2  echoed ID, response code.
REQ-013 io_ddrA_r_valid/ready  output/input  1/1  read data handshake.
REQ-014 io_ddrA_r_payload_data/id/resp/last  output  128/ID_WIDTH/2/1  read data, echoed ID, response, last beat.

Function
REQ-015 FSM states SHALL be IDLE, WRITE, WRESP, READ; one transaction outstanding at a time.
REQ-016 arw_ready SHALL be 1 only in IDLE; on arw handshake, addr/id/len/burst/write are latched and state moves to WRITE (write=1) or READ (write=0).
REQ-017 Word index SHALL be addr[4+log2(MEM_WORDS)-1:4]; addr[3:0] and size are ignored, every beat is 16 bytes.
REQ-018 Burst 00 (FIXED) SHALL hold the word index for all beats; 01 and all other codes SHALL increment by 1 per beat, wrapping modulo MEM_WORDS.
REQ-019 A transaction whose start addr >= MEM_WORDS*16 SHALL be a decode error: resp 2'b11, writes discarded, read data all-zero; otherwise resp 2'b00.
REQ-020 Beat counter SHALL be 9 bits, cleared on arw handshake; burst ends when counter == len, supporting len 0..255 (1..256 beats).
REQ-021 WRITE: w_ready SHALL be 1 from the cycle after arw handshake; each w handshake writes byte i of the word iff strb[i]=1.
REQ-022 w_payload_last SHALL be ignored; the beat counter alone terminates the burst.
REQ-023 After the final w handshake, state SHALL move to WRESP with b_valid=1 the next cycle, b_payload_id = latched id, held stable until b_ready, then return to IDLE.
REQ-024 READ: backing RAM read latency SHALL be 1 cycle; first r_valid SHALL assert 2 cycles after arw handshake.
REQ-025 With r_ready held high, read beats SHALL issue back-to-back (one per cycle) after the first.
REQ-026 While r_valid=1 and r_ready=0, r_payload_data/id/resp/last SHALL remain stable and no beat is skipped or duplicated.
REQ-027 r_payload_last SHALL be 1 exactly on beat len; on its handshake state returns to IDLE and r_valid deasserts next cycle unless arw handshake restarts.
REQ-028 Back-to-back transactions SHALL be allowed: arw_ready reasserts the cycle the FSM re-enters IDLE.
REQ-029 Write to word N followed by read of word N SHALL return the written data (no stale read).

Reset
REQ-030 While io_memoryReset=1: state IDLE, arw_ready=0, w_ready=0, b_valid=0, r_valid=0, r_payload_last=0, b/r resp and id 0, counter 0.
REQ-031 arw_ready SHALL assert the first cycle after reset deasserts.
REQ-032 Reset mid-transaction SHALL abort it without completing responses; RAM contents SHALL NOT be reset and beats already written SHALL persist.

Verification
REQ-033 Write len=0 addr 0x100 id 0x5A data 0x0011..FF strb 0xFFFF -> b_valid 1 cycle after w handshake, b_id 0x5A, resp 00; read back returns same data, r_last=1.
REQ-034 INCR write len=3 at 0x200 data D0..D3, then INCR read len=3 at 0x200 -> 4 beats D0..D3 back-to-back, r_last only on beat 4, first r_valid 2 cycles after arw.
REQ-035 Word all 0xFF, write strb 0x000F data 0 -> read returns low 4 bytes 0x00, upper 12 bytes 0xFF.
REQ-036 Read len=7 with r_ready random 50% -> 8 distinct correct beats, payload stable during every stall.
REQ-037 Read at addr MEM_WORDS*16 len=1 -> 2 beats, resp 2'b11, data 0; FIXED write len=2 to 0x300 -> only last beat retained at word 0x30.
REQ-038 Reset asserted on beat 2 of read len=7 -> r_valid 0 next cycle, arw_ready 1 first cycle after release, subsequent read returns prior data.
